// File: rtl/cpri_prb_pattern_player.sv
// rtl/cpri_prb_pattern_player.sv - chip-aligned per-lane PRB pattern frame player
module cpri_prb_pattern_player #(
  parameter int NUM_CH    = 8,
  parameter int DAT_DW    = 64,
  parameter int CHIP_LEN  = 96,
  parameter int SOP_POS   = 3,
  parameter int FRAME_LEN = 44352,
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rfp_rise,
  input  logic                     enable,
  input  logic [1:0]               mode,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [NUM_CH*DAT_DW-1:0] mem_rd_q,
  output logic                     sop_o,
  output logic                     vld_o,
  output logic [NUM_CH*DAT_DW-1:0] dat_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic [7:0]               rfp_ign_cnt_o
);

  localparam int CW = (CHIP_LEN > 1) ? $clog2(CHIP_LEN) : 1;
  localparam logic [CW-1:0]     CHIP_LAST  = CW'(CHIP_LEN - 1);
  localparam logic [CW-1:0]     SOP_IDX    = CW'(SOP_POS);
  localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(FRAME_LEN - 1);

  // Reject geometries the player cannot replay chip-aligned
  if (FRAME_LEN % CHIP_LEN != 0) begin : g_chk_frame
    $error("FRAME_LEN must be a multiple of CHIP_LEN");
  end
  if (SOP_POS >= CHIP_LEN) begin : g_chk_sop
    $error("SOP_POS must be below CHIP_LEN");
  end
  if (longint'(FRAME_LEN) > (longint'(1) << ADDR_W)) begin : g_chk_addr
    $error("FRAME_LEN does not fit in ADDR_W address bits");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_lat
    $error("RD_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {IDLE, ARMED, PLAY} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [1:0]        mode_l, mode_n;
  logic              last_os;
  logic [CW-1:0]     chip_cnt;
  logic              chip_strb;
  logic [RD_LAT-1:0] rd_pipe;
  logic [RD_LAT-1:0] done_pipe;
  logic [RD_LAT:0]   sop_pipe;

  assign chip_strb   = (chip_cnt == SOP_IDX);
  assign mem_rd_en   = (state == PLAY);
  assign mem_rd_addr = (state == PLAY) ? addr : '0;
  assign busy_o      = (state == ARMED) || (state == PLAY);
  assign sop_o       = sop_pipe[RD_LAT];

  // Free-running chip position, independent of playback state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        chip_cnt <= '0;
    else if (chip_cnt == CHIP_LAST) chip_cnt <= '0;
    else                            chip_cnt <= chip_cnt + 1'b1;
  end

  // Player state, read address and latched mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      mode_l <= '0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      mode_l <= mode_n;
    end
  end

  // Next-state: arm on RFP, start on chip boundary, wrap or finish at frame end
  always_comb begin
    state_n = state;
    addr_n  = addr;
    mode_n  = mode_l;
    last_os = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      addr_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rfp_rise && (mode == 2'd1 || mode == 2'd2)) begin
            state_n = ARMED;
            mode_n  = mode;
          end
        end
        ARMED: begin
          addr_n = '0;
          if (chip_cnt == CHIP_LAST) state_n = PLAY;
        end
        PLAY: begin
          if (addr == FRAME_LAST) begin
            addr_n = '0;
            if (mode_l != 2'd2) begin
              state_n = IDLE;
              last_os = 1'b1;
            end
          end else begin
            addr_n = addr + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          addr_n  = '0;
        end
      endcase
    end
  end

  // Count RFP strobes that arrive while a frame is armed or playing
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rfp_ign_cnt_o <= '0;
    else if (rfp_rise && state != IDLE && rfp_ign_cnt_o != 8'hFF)
      rfp_ign_cnt_o <= rfp_ign_cnt_o + 8'd1;
  end

  // Delay read-enable, frame-end and chip strobe to match memory latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe   <= '0;
      done_pipe <= '0;
      sop_pipe  <= '0;
    end else begin
      rd_pipe[0]   <= mem_rd_en;
      done_pipe[0] <= last_os;
      sop_pipe[0]  <= chip_strb;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i]   <= rd_pipe[i-1];
        done_pipe[i] <= done_pipe[i-1];
      end
      for (int i = 1; i <= RD_LAT; i++) begin
        sop_pipe[i] <= sop_pipe[i-1];
      end
    end
  end

  // Register lane data; zero whenever no pattern word is present
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_o        <= 1'b0;
      frame_done_o <= 1'b0;
      dat_o        <= '0;
    end else begin
      vld_o        <= rd_pipe[RD_LAT-1];
      frame_done_o <= done_pipe[RD_LAT-1];
      dat_o        <= rd_pipe[RD_LAT-1] ? mem_rd_q : '0;
    end
  end

endmodule

// File: tb/tb_cpri_prb_pattern_player.sv
// tb/tb_cpri_prb_pattern_player.sv - directed table-driven bench for the PRB pattern player
module tb_cpri_prb_pattern_player;

  localparam int NUM_CH = 2, DAT_DW = 16, CHIP_LEN = 8, SOP_POS = 3;
  localparam int FRAME_LEN = 32, ADDR_W = 16, RD_LAT = 1;

  logic                     clk, rst, rfp_rise, enable;
  logic [1:0]               mode;
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_rd_addr;
  logic [NUM_CH*DAT_DW-1:0] mem_rd_q;
  logic                     sop_o, vld_o, busy_o, frame_done_o;
  logic [NUM_CH*DAT_DW-1:0] dat_o;
  logic [7:0]               rfp_ign_cnt_o;

  cpri_prb_pattern_player #(
    .NUM_CH(NUM_CH), .DAT_DW(DAT_DW), .CHIP_LEN(CHIP_LEN), .SOP_POS(SOP_POS),
    .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .rfp_rise(rfp_rise), .enable(enable), .mode(mode),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_q(mem_rd_q),
    .sop_o(sop_o), .vld_o(vld_o), .dat_o(dat_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .rfp_ign_cnt_o(rfp_ign_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern memory: lane0 = addr, lane1 = addr + 0x100, one cycle latency
  always @(posedge clk) mem_rd_q <= {16'(mem_rd_addr + 16'h0100), mem_rd_addr};

  typedef struct {
    bit rfp; bit en; bit [1:0] mode;
    bit rd_en; int addr; bit vld; int lane0; int lane1;
    bit sop; bit busy; bit done; int ign;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0, failures = 0;
  int   cc = 0;
  int   j;
  bit   done_seen, found;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cc = (cc + 1) % CHIP_LEN;
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      rfp_rise = tbl[i].rfp; enable = tbl[i].en; mode = tbl[i].mode;
      chk($sformatf("%s[%0d].rd_en", tag, i), int'(mem_rd_en), int'(tbl[i].rd_en));
      chk($sformatf("%s[%0d].addr",  tag, i), int'(mem_rd_addr), tbl[i].addr);
      chk($sformatf("%s[%0d].vld",   tag, i), int'(vld_o), int'(tbl[i].vld));
      chk($sformatf("%s[%0d].lane0", tag, i), int'(dat_o[15:0]), tbl[i].lane0);
      chk($sformatf("%s[%0d].lane1", tag, i), int'(dat_o[31:16]), tbl[i].lane1);
      chk($sformatf("%s[%0d].sop",   tag, i), int'(sop_o), int'(tbl[i].sop));
      chk($sformatf("%s[%0d].busy",  tag, i), int'(busy_o), int'(tbl[i].busy));
      chk($sformatf("%s[%0d].done",  tag, i), int'(frame_done_o), int'(tbl[i].done));
      chk($sformatf("%s[%0d].ign",   tag, i), int'(rfp_ign_cnt_o), tbl[i].ign);
      step();
    end
    rfp_rise = 1'b0;
  endtask

  task automatic wait_cc(input int target);
    while (cc != target) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; rfp_rise = 1'b0; enable = 1'b0; mode = 2'd0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; cc = 0;

    chk("reset.rd_en", int'(mem_rd_en), 0);
    chk("reset.addr",  int'(mem_rd_addr), 0);
    chk("reset.vld",   int'(vld_o), 0);
    chk("reset.dat",   int'(dat_o), 0);
    chk("reset.sop",   int'(sop_o), 0);
    chk("reset.busy",  int'(busy_o), 0);
    chk("reset.done",  int'(frame_done_o), 0);
    chk("reset.ign",   int'(rfp_ign_cnt_o), 0);

    // Off and reserved modes must not arm or count
    enable = 1'b1;
    for (int m = 0; m < 2; m++) begin
      mode = (m == 0) ? 2'd0 : 2'd3;
      rfp_rise = 1'b1; step(); rfp_rise = 1'b0; step();
      chk($sformatf("off_mode%0d.busy", mode), int'(busy_o), 0);
      chk($sformatf("off_mode%0d.rd_en", mode), int'(mem_rd_en), 0);
      chk($sformatf("off_mode%0d.ign", mode), int'(rfp_ign_cnt_o), 0);
    end

    // One-shot: rfp at chip_cnt=2, read 0 at chip_cnt=0 six cycles later
    tbl.delete();
    for (int k = 0; k < 45; k++) begin
      v.rfp = (k == 0); v.en = 1'b1; v.mode = 2'd1;
      v.rd_en = (k >= 6 && k <= 37);
      v.addr  = v.rd_en ? k - 6 : 0;
      v.vld   = (k >= 8 && k <= 39);
      v.lane0 = v.vld ? k - 8 : 0;
      v.lane1 = v.vld ? k - 8 + 256 : 0;
      v.sop   = (((2 + k) % CHIP_LEN) == SOP_POS + 2);
      v.busy  = (k >= 1 && k <= 37);
      v.done  = (k == 39);
      v.ign   = 0;
      tbl.push_back(v);
    end
    mode = 2'd1;
    wait_cc(2);
    run_tbl("oneshot");

    // Abort: enable drops while address 10 is being read
    rfp_rise = 1'b1; step(); rfp_rise = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (mem_rd_en && mem_rd_addr == 16'd10) found = 1'b1;
      else step();
    end
    chk("abort.reached_addr10", int'(found), 1);
    enable = 1'b0;
    step();
    chk("abort.t1.rd_en", int'(mem_rd_en), 0);
    chk("abort.t1.busy",  int'(busy_o), 0);
    chk("abort.t1.vld",   int'(vld_o), 1);
    chk("abort.t1.lane0", int'(dat_o[15:0]), 9);
    chk("abort.t1.done",  int'(frame_done_o), 0);
    step();
    chk("abort.t2.vld",   int'(vld_o), 1);
    chk("abort.t2.lane0", int'(dat_o[15:0]), 10);
    chk("abort.t2.done",  int'(frame_done_o), 0);
    step();
    chk("abort.t3.vld",   int'(vld_o), 0);
    chk("abort.t3.dat",   int'(dat_o), 0);
    chk("abort.t3.done",  int'(frame_done_o), 0);
    chk("abort.t3.rd_en", int'(mem_rd_en), 0);
    enable = 1'b1;
    step(); step();

    // Continuous with three ignored RFPs during play
    tbl.delete();
    for (int k = 0; k < 109; k++) begin
      v.rfp = (k == 0 || k == 20 || k == 21 || k == 25); v.en = 1'b1; v.mode = 2'd2;
      v.rd_en = (k >= 6);
      v.addr  = v.rd_en ? (k - 6) % FRAME_LEN : 0;
      v.vld   = (k >= 8);
      v.lane0 = v.vld ? (k - 8) % FRAME_LEN : 0;
      v.lane1 = v.vld ? (k - 8) % FRAME_LEN + 256 : 0;
      v.sop   = (((2 + k) % CHIP_LEN) == SOP_POS + 2);
      v.busy  = (k >= 1);
      v.done  = 1'b0;
      v.ign   = int'(k > 20) + int'(k > 21) + int'(k > 25);
      tbl.push_back(v);
    end
    mode = 2'd2;
    wait_cc(2);
    run_tbl("cont");
    chk("ign.after3", int'(rfp_ign_cnt_o), 3);

    // 300 more ignored pulses: counter saturates, playback unperturbed
    done_seen = 1'b0;
    j = 109;
    for (int k = 0; k < 300; k++) begin
      rfp_rise = 1'b1;
      chk($sformatf("rfp_flood[%0d].vld", k), int'(vld_o), 1);
      chk($sformatf("rfp_flood[%0d].lane0", k), int'(dat_o[15:0]), (j - 8) % FRAME_LEN);
      if (frame_done_o) done_seen = 1'b1;
      step();
      j++;
    end
    rfp_rise = 1'b0;
    chk("ign.saturated", int'(rfp_ign_cnt_o), 255);
    chk("cont.busy_held", int'(busy_o), 1);
    chk("cont.no_done", int'(done_seen), 0);

    // Asynchronous reset mid-play clears outputs without a clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("arst.rd_en", int'(mem_rd_en), 0);
    chk("arst.addr",  int'(mem_rd_addr), 0);
    chk("arst.vld",   int'(vld_o), 0);
    chk("arst.dat",   int'(dat_o), 0);
    chk("arst.sop",   int'(sop_o), 0);
    chk("arst.busy",  int'(busy_o), 0);
    chk("arst.done",  int'(frame_done_o), 0);
    chk("arst.ign",   int'(rfp_ign_cnt_o), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; cc = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("post_rst[%0d].sop", k), int'(sop_o), int'(k == SOP_POS + RD_LAT + 1));
      chk($sformatf("post_rst[%0d].busy", k), int'(busy_o), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpri_prb_pattern_player.md
Name: cpri_prb_pattern_player

Overview:
- Parametrised successor to the fixed 8-lane CPRI test-pattern generator.
- Plays a stored per-lane PRB pattern frame, chip-aligned, after an RFP trigger. Supports one-shot, continuous and off modes, and a configurable lane count and frame geometry.
- Drives an external pattern-memory read port. Outputs lane data with sop and valid pulses aligned to that data, plus status for the upstream CPRI mux.

Parameters:
- NUM_CH, 8, number of parallel CPRI lanes
- DAT_DW, 64, bits per lane word
- CHIP_LEN, 96, cycles per chip
- SOP_POS, 3, chip index at which sop is flagged (0..CHIP_LEN-1)
- FRAME_LEN, 44352, words per pattern frame; must be a multiple of CHIP_LEN
- ADDR_W, 16, memory address width; FRAME_LEN <= 2^ADDR_W
- RD_LAT, 1, memory read latency in cycles (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rfp_rise  in  1  single-cycle radio-frame-pulse rising-edge strobe
- enable  in  1  player enable; deassertion aborts playback
- mode  in  2  0 = off, 1 = one-shot, 2 = continuous, 3 = reserved (treated as off)
- mem_rd_en  out  1  memory read enable
- mem_rd_addr  out  ADDR_W  memory read address
- mem_rd_q  in  NUM_CH*DAT_DW  memory read data; lane k occupies bits [k*DAT_DW +: DAT_DW]
- sop_o  out  1  chip start-of-packet, aligned with dat_o
- vld_o  out  1  dat_o holds pattern data
- dat_o  out  NUM_CH*DAT_DW  lane data, zero when vld_o = 0
- busy_o  out  1  state is ARMED or PLAY
- frame_done_o  out  1  one-cycle pulse when a one-shot frame completes
- rfp_ign_cnt_o  out  8  saturating count of ignored rfp_rise strobes

Behaviour:
- Reset values:
  - All outputs 0.
  - chip_cnt = 0, state = IDLE, address = 0.
  - Delay pipelines are cleared asynchronously.
- chip_cnt:
  - Free-runs 0..CHIP_LEN-1 and wraps; independent of state.
  - Chip strobe = (chip_cnt == SOP_POS).
- State machine:
  - IDLE -> ARMED on rfp_rise & enable & mode in {1,2}. mode is latched into mode_l at this transition.
  - ARMED -> PLAY when chip_cnt == CHIP_LEN-1. The first read (address 0) is issued in the next cycle, where chip_cnt == 0.
  - PLAY: mem_rd_en = 1 and the address increments each cycle. At address FRAME_LEN-1:
    - mode_l = 2: the address wraps to 0 and the state stays PLAY (seamless, chip-aligned).
    - mode_l = 1: go to IDLE; frame_done_o pulses once, aligned with the last vld_o cycle.
  - Any state -> IDLE on the cycle after enable = 0. No frame_done_o is issued on abort. Pipeline data already in flight still emerges with vld_o.
  - mode changes while ARMED or PLAY are ignored until the next arm.
- rfp_rise handling:
  - rfp_rise in ARMED or PLAY is ignored and increments rfp_ign_cnt_o, saturating at 255.
  - rfp_rise in IDLE with mode in {0,3} or enable = 0 is ignored and not counted.
  - rfp_rise coinciding with the one-shot final-address cycle is counted, not armed.
- Outside PLAY: mem_rd_en = 0 and mem_rd_addr = 0.
- Latency:
  - A read issued at cycle t returns mem_rd_q at t+RD_LAT.
  - dat_o and vld_o are registered at t+RD_LAT+1.
  - sop_o is the chip strobe delayed by RD_LAT+1, so in every played chip sop_o coincides with word index SOP_POS. sop_o toggles in all states.
- dat_o is forced to 0 whenever vld_o = 0.
- Elaboration checks: the block must fail elaboration if FRAME_LEN % CHIP_LEN != 0, SOP_POS >= CHIP_LEN, or FRAME_LEN > 2^ADDR_W.

Test Plan:
- Test setup: CHIP_LEN=8, FRAME_LEN=32, SOP_POS=3, RD_LAT=1, NUM_CH=2, DAT_DW=16. The memory model returns {addr+0x100, addr} per lane.
- One-shot:
  - Stimulus: mode=1, rfp_rise while chip_cnt=2.
  - Required: the read of address 0 occurs at the next chip_cnt=0. vld_o is high for exactly 32 cycles with lane0 = 0..31. sop_o is seen on lane0 words 3, 11, 19, 27. frame_done_o pulses with word 31, then busy_o = 0.
- Continuous:
  - Stimulus: mode=2, run for 100 cycles after first vld_o.
  - Required: lane0 sequence 0..31, 0..31, ... with no gap at the wrap. busy_o stays 1 and frame_done_o never fires.
- Abort:
  - Stimulus: drop enable at address 10.
  - Required: mem_rd_en is 0 from the next cycle. Words up to 10 still appear on dat_o, then vld_o = 0 and dat_o = 0. No frame_done_o.
- Ignored RFP:
  - Stimulus: 3 rfp_rise pulses during PLAY, then 300 more.
  - Required: rfp_ign_cnt_o = 3, then saturates at 255. Playback is unperturbed.
- Mode off/reserved and reset:
  - Stimulus: rfp_rise with mode=0, then with mode=3.
  - Required: no arm occurs and the counter is unchanged.
  - Stimulus: assert rst mid-PLAY, asynchronously.
  - Required: all outputs are 0 immediately, without waiting for a clock edge. After release the state is IDLE, and the first sop_o appears RD_LAT+1 cycles after chip_cnt reaches 3.
